// File: rtl/mem_stage.sv
// Memory-access pipeline stage: latches the execute bus, aligns and extends SRAM load data,
// and hands the result to writeback. Define MEM_LOAD_STATS_EN to add the retired-load counter.
module mem_stage #(
    parameter int EX_BUS_W = 108,
    parameter int WB_BUS_W = 70
) (
    input  logic                clk,
    input  logic                resetn,
    output logic                mem_allowin,
    input  logic                ex_to_mem_valid,
    input  logic [EX_BUS_W-1:0] ex_to_mem_bus,
    input  logic                wb_allowin,
    output logic                mem_to_wb_valid,
    output logic [WB_BUS_W-1:0] mem_to_wb_bus,
    output logic [37:0]         mem_to_id_bus,
    input  logic [31:0]         data_sram_rdata
`ifdef MEM_LOAD_STATS_EN
    ,
    output logic [31:0]         load_cnt
`endif
);

    logic                mem_valid_q, mem_valid_d;
    logic [EX_BUS_W-1:0] bus_q, bus_d;
    logic                rdata_first_q, rdata_first_d;
    logic                buf_vld_q, buf_vld_d;
    logic [31:0]         rdata_buf_q, rdata_buf_d;

    logic        mem_ready_go;
    logic        accept;
    logic        leave;
    logic [31:0] pc;
    logic        res_from_mem;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] alu_result;
    logic [31:0] rkd_value;
    logic [1:0]  addr_lo;
    logic        op_b, op_h, op_u;
    logic [31:0] rdata_eff;
    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic [31:0] load_data;
    logic [31:0] final_result;
    logic        unused_rkd;

    assign {pc, res_from_mem, rf_we, rf_waddr, alu_result, rkd_value,
            addr_lo, op_b, op_h, op_u} = bus_q;
    assign unused_rkd = ^rkd_value;

    assign mem_ready_go    = 1'b1;
    assign mem_allowin     = ~mem_valid_q | (mem_ready_go & wb_allowin);
    assign mem_to_wb_valid = mem_valid_q & mem_ready_go;
    assign accept          = ex_to_mem_valid & mem_allowin;
    assign leave           = mem_to_wb_valid & wb_allowin;

    // SRAM data is only valid the cycle after the request; a stalled load replays from the buffer.
    assign rdata_eff = buf_vld_q ? rdata_buf_q : data_sram_rdata;

    always_comb begin
        byte_val  = 8'(rdata_eff >> {addr_lo, 3'b000});
        half_val  = 16'(rdata_eff >> {addr_lo[1], 4'b0000});
        load_data = rdata_eff;
        if (op_b) begin
            load_data = {{24{byte_val[7] & ~op_u}}, byte_val};
        end else if (op_h) begin
            load_data = {{16{half_val[15] & ~op_u}}, half_val};
        end
        final_result = res_from_mem ? load_data : alu_result;
    end

    assign mem_to_wb_bus = {pc, rf_we & mem_valid_q, rf_waddr, final_result};
    assign mem_to_id_bus = {rf_we & mem_valid_q, rf_waddr, final_result};

    always_comb begin
        mem_valid_d   = mem_valid_q;
        bus_d         = bus_q;
        rdata_first_d = accept;
        buf_vld_d     = buf_vld_q;
        rdata_buf_d   = rdata_buf_q;
        if (mem_allowin) begin
            mem_valid_d = ex_to_mem_valid;
        end
        if (accept) begin
            bus_d = ex_to_mem_bus;
        end
        if (leave) begin
            buf_vld_d = 1'b0;
        end else if (mem_valid_q & rdata_first_q & ~wb_allowin) begin
            buf_vld_d   = 1'b1;
            rdata_buf_d = data_sram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_valid_q   <= 1'b0;
            bus_q         <= '0;
            rdata_first_q <= 1'b0;
            buf_vld_q     <= 1'b0;
            rdata_buf_q   <= '0;
        end else begin
            mem_valid_q   <= mem_valid_d;
            bus_q         <= bus_d;
            rdata_first_q <= rdata_first_d;
            buf_vld_q     <= buf_vld_d;
            rdata_buf_q   <= rdata_buf_d;
        end
    end

`ifdef MEM_LOAD_STATS_EN
    logic [31:0] load_cnt_q, load_cnt_d;

    always_comb begin
        load_cnt_d = load_cnt_q;
        if (leave & res_from_mem) begin
            load_cnt_d = load_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            load_cnt_q <= '0;
        end else begin
            load_cnt_q <= load_cnt_d;
        end
    end

    assign load_cnt = load_cnt_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: reset, load alignment, stall replay,
// back-to-back flow, reset during stall, and (with MEM_LOAD_STATS_EN) the load counter.
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         resetn;
    logic         mem_allowin;
    logic         ex_to_mem_valid;
    logic [107:0] ex_to_mem_bus;
    logic         wb_allowin;
    logic         mem_to_wb_valid;
    logic [69:0]  mem_to_wb_bus;
    logic [37:0]  mem_to_id_bus;
    logic [31:0]  data_sram_rdata;
`ifdef MEM_LOAD_STATS_EN
    logic [31:0]  load_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    mem_stage dut (
        .clk             (clk),
        .resetn          (resetn),
        .mem_allowin     (mem_allowin),
        .ex_to_mem_valid (ex_to_mem_valid),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .wb_allowin      (wb_allowin),
        .mem_to_wb_valid (mem_to_wb_valid),
        .mem_to_wb_bus   (mem_to_wb_bus),
        .mem_to_id_bus   (mem_to_id_bus),
        .data_sram_rdata (data_sram_rdata)
`ifdef MEM_LOAD_STATS_EN
        ,
        .load_cnt        (load_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [107:0] mk_bus(input logic [31:0] pc, input logic rfm,
                                            input logic we, input logic [4:0] wa,
                                            input logic [31:0] alu, input logic [1:0] lo,
                                            input logic [2:0] bhu);
        return {pc, rfm, we, wa, alu, 32'h0BAD0BAD, lo, bhu};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        ex_to_mem_valid = 1'b0;
        ex_to_mem_bus = '0;
        wb_allowin = 1'b1;
        data_sram_rdata = 32'h0;
        tick();
        tick();
        #1;
        checks++;
        if (mem_to_wb_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%b want=0", mem_to_wb_valid);
        end
        checks++;
        if (mem_allowin !== 1'b1) begin
            failures++;
            $display("FAIL reset_allowin got=%b want=1", mem_allowin);
        end
        checks++;
        if (mem_to_id_bus[37] !== 1'b0) begin
            failures++;
            $display("FAIL reset_id_we got=%b want=0", mem_to_id_bus[37]);
        end
        checks++;
        if (mem_to_wb_bus !== 70'h0) begin
            failures++;
            $display("FAIL reset_wb_bus got=%h want=0", mem_to_wb_bus);
        end
        $display("txn reset: valid=%b allowin=%b", mem_to_wb_valid, mem_allowin);
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_loads();
        logic [2:0]  ops [0:8];
        logic [1:0]  los [0:8];
        logic [31:0] rds [0:8];
        logic [31:0] exp [0:8];
        ops = '{3'b100, 3'b101, 3'b010, 3'b011, 3'b000, 3'b010, 3'b100, 3'b000, 3'b100};
        los = '{2'd2,   2'd2,   2'd2,   2'd2,   2'd0,   2'd3,   2'd1,   2'd3,   2'd3};
        rds = '{32'h12C45678, 32'h12C45678, 32'h8001ABCD, 32'h8001ABCD, 32'h8001ABCD,
                32'h8001ABCD, 32'h12C45678, 32'h8001ABCD, 32'h8F000000};
        exp = '{32'hFFFFFFC4, 32'h000000C4, 32'hFFFF8001, 32'h00008001, 32'h8001ABCD,
                32'hFFFF8001, 32'h00000056, 32'h8001ABCD, 32'hFFFFFF8F};
        wb_allowin = 1'b1;
        for (int i = 0; i < 9; i++) begin
            ex_to_mem_valid = 1'b1;
            ex_to_mem_bus = mk_bus(32'h1000 + 32'(4 * i), 1'b1, 1'b1, 5'(i + 1),
                                   32'h00000400, los[i], ops[i]);
            tick();
            ex_to_mem_valid = 1'b0;
            data_sram_rdata = rds[i];
            #1;
            checks++;
            if (mem_to_wb_valid !== 1'b1 || mem_to_wb_bus[37] !== 1'b1) begin
                failures++;
                $display("FAIL load%0d_valid_we got=%b/%b want=1/1", i, mem_to_wb_valid,
                         mem_to_wb_bus[37]);
            end
            checks++;
            if (mem_to_wb_bus[31:0] !== exp[i] || mem_to_id_bus[31:0] !== exp[i]) begin
                failures++;
                $display("FAIL load%0d_result got=%h/%h want=%h", i, mem_to_wb_bus[31:0],
                         mem_to_id_bus[31:0], exp[i]);
            end
            checks++;
            if (mem_to_wb_bus[69:38] !== 32'h1000 + 32'(4 * i) ||
                mem_to_wb_bus[36:32] !== 5'(i + 1)) begin
                failures++;
                $display("FAIL load%0d_pc_waddr got=%h/%0d want=%h/%0d", i,
                         mem_to_wb_bus[69:38], mem_to_wb_bus[36:32],
                         32'h1000 + 32'(4 * i), i + 1);
            end
            $display("txn load%0d: bhu=%b lo=%0d rdata=%h result=%h", i, ops[i], los[i],
                     rds[i], mem_to_wb_bus[31:0]);
        end
        tick();
        checks++;
        if (mem_to_wb_valid !== 1'b0) begin
            failures++;
            $display("FAIL loads_drain got=%b want=0", mem_to_wb_valid);
        end
    endtask

    task automatic test_stall();
        wb_allowin = 1'b0;
        ex_to_mem_valid = 1'b1;
        ex_to_mem_bus = mk_bus(32'h2000, 1'b1, 1'b1, 5'd7, 32'h2000, 2'd0, 3'b000);
        tick();
        ex_to_mem_bus = mk_bus(32'h2004, 1'b0, 1'b1, 5'd9, 32'h99, 2'd0, 3'b000);
        data_sram_rdata = 32'h11223344;
        #1;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (mem_allowin !== 1'b0 || mem_to_wb_valid !== 1'b1) begin
                failures++;
                $display("FAIL stall%0d_allowin_valid got=%b/%b want=0/1", c, mem_allowin,
                         mem_to_wb_valid);
            end
            checks++;
            if (mem_to_wb_bus[31:0] !== 32'h11223344 || mem_to_wb_bus[69:38] !== 32'h2000) begin
                failures++;
                $display("FAIL stall%0d_hold got=%h pc=%h want=11223344 pc=2000", c,
                         mem_to_wb_bus[31:0], mem_to_wb_bus[69:38]);
            end
            $display("txn stall cycle %0d: result=%h", c, mem_to_wb_bus[31:0]);
            if (c < 2) begin
                tick();
                data_sram_rdata = 32'hDEADBEEF;
                #1;
            end
        end
        wb_allowin = 1'b1;
        #1;
        checks++;
        if (mem_allowin !== 1'b1 || mem_to_wb_bus[31:0] !== 32'h11223344) begin
            failures++;
            $display("FAIL stall_release got allowin=%b res=%h want 1/11223344", mem_allowin,
                     mem_to_wb_bus[31:0]);
        end
        tick();
        ex_to_mem_valid = 1'b0;
        #1;
        checks++;
        if (mem_to_wb_valid !== 1'b1 || mem_to_wb_bus[69:38] !== 32'h2004 ||
            mem_to_wb_bus[31:0] !== 32'h99 || mem_to_wb_bus[37:32] !== 6'b1_01001) begin
            failures++;
            $display("FAIL stall_next_alu got v=%b pc=%h we_wa=%b res=%h want 1/2004/101001/99",
                     mem_to_wb_valid, mem_to_wb_bus[69:38], mem_to_wb_bus[37:32],
                     mem_to_wb_bus[31:0]);
        end
        $display("txn stall handoff: next pc=%h result=%h", mem_to_wb_bus[69:38],
                 mem_to_wb_bus[31:0]);
        ex_to_mem_valid = 1'b1;
        ex_to_mem_bus = mk_bus(32'h2008, 1'b1, 1'b1, 5'd10, 32'h0, 2'd0, 3'b000);
        tick();
        ex_to_mem_valid = 1'b0;
        data_sram_rdata = 32'hCAFEF00D;
        #1;
        checks++;
        if (mem_to_wb_bus[31:0] !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL stall_buf_cleared got=%h want=cafef00d", mem_to_wb_bus[31:0]);
        end
        $display("txn post-stall load: result=%h", mem_to_wb_bus[31:0]);
        tick();
    endtask

    task automatic test_back_to_back();
        wb_allowin = 1'b1;
        ex_to_mem_valid = 1'b1;
        ex_to_mem_bus = mk_bus(32'h3000, 1'b0, 1'b0, 5'd4, 32'h1000, 2'd0, 3'b000);
        tick();
        ex_to_mem_bus = mk_bus(32'h3004, 1'b0, 1'b1, 5'd3, 32'h55, 2'd0, 3'b000);
        #1;
        checks++;
        if (mem_to_wb_valid !== 1'b1 || mem_to_wb_bus[37] !== 1'b0 ||
            mem_to_id_bus[37] !== 1'b0 || mem_to_wb_bus[31:0] !== 32'h1000) begin
            failures++;
            $display("FAIL b2b_store got v=%b we=%b/%b res=%h want 1/0/0/1000", mem_to_wb_valid,
                     mem_to_wb_bus[37], mem_to_id_bus[37], mem_to_wb_bus[31:0]);
        end
        checks++;
        if (mem_allowin !== 1'b1) begin
            failures++;
            $display("FAIL b2b_allowin_store got=%b want=1", mem_allowin);
        end
        $display("txn store: we=%b result=%h", mem_to_wb_bus[37], mem_to_wb_bus[31:0]);
        tick();
        ex_to_mem_valid = 1'b0;
        #1;
        checks++;
        if (mem_to_wb_valid !== 1'b1 || mem_to_wb_bus[37] !== 1'b1 ||
            mem_to_wb_bus[36:32] !== 5'd3 || mem_to_id_bus[31:0] !== 32'h55) begin
            failures++;
            $display("FAIL b2b_alu got v=%b we=%b wa=%0d res=%h want 1/1/3/55", mem_to_wb_valid,
                     mem_to_wb_bus[37], mem_to_wb_bus[36:32], mem_to_id_bus[31:0]);
        end
        $display("txn alu: we=%b result=%h", mem_to_wb_bus[37], mem_to_id_bus[31:0]);
        tick();
        checks++;
        if (mem_to_wb_valid !== 1'b0 || mem_to_id_bus[37] !== 1'b0 || mem_allowin !== 1'b1) begin
            failures++;
            $display("FAIL b2b_empty got v=%b we=%b allowin=%b want 0/0/1", mem_to_wb_valid,
                     mem_to_id_bus[37], mem_allowin);
        end
    endtask

    task automatic test_reset_mid_stall();
        wb_allowin = 1'b0;
        ex_to_mem_valid = 1'b1;
        ex_to_mem_bus = mk_bus(32'h4000, 1'b1, 1'b1, 5'd12, 32'h0, 2'd0, 3'b000);
        tick();
        ex_to_mem_valid = 1'b0;
        data_sram_rdata = 32'hAAAA5555;
        tick();
        resetn = 1'b0;
        tick();
        #1;
        checks++;
        if (mem_to_wb_valid !== 1'b0 || mem_to_id_bus[37] !== 1'b0 || mem_allowin !== 1'b1) begin
            failures++;
            $display("FAIL rst_stall got v=%b we=%b allowin=%b want 0/0/1", mem_to_wb_valid,
                     mem_to_id_bus[37], mem_allowin);
        end
        $display("txn reset mid-stall: valid=%b id_we=%b", mem_to_wb_valid, mem_to_id_bus[37]);
        resetn = 1'b1;
        wb_allowin = 1'b1;
        ex_to_mem_valid = 1'b1;
        ex_to_mem_bus = mk_bus(32'h4004, 1'b1, 1'b1, 5'd13, 32'h0, 2'd0, 3'b000);
        tick();
        ex_to_mem_valid = 1'b0;
        data_sram_rdata = 32'h0F0F1234;
        #1;
        checks++;
        if (mem_to_wb_bus[31:0] !== 32'h0F0F1234) begin
            failures++;
            $display("FAIL rst_stall_buf_dropped got=%h want=0f0f1234", mem_to_wb_bus[31:0]);
        end
        tick();
    endtask

`ifdef MEM_LOAD_STATS_EN
    task automatic test_load_stats();
        logic [4:0] rfm_seq;
        rfm_seq = 5'b10101;
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        #1;
        checks++;
        if (load_cnt !== 32'd0) begin
            failures++;
            $display("FAIL cnt_reset got=%0d want=0", load_cnt);
        end
        wb_allowin = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ex_to_mem_valid = 1'b1;
            ex_to_mem_bus = mk_bus(32'h5000 + 32'(4 * i), rfm_seq[i], rfm_seq[i], 5'd1,
                                   32'h0, 2'd0, 3'b000);
            tick();
        end
        ex_to_mem_valid = 1'b0;
        tick();
        checks++;
        if (load_cnt !== 32'd3) begin
            failures++;
            $display("FAIL cnt_three got=%0d want=3", load_cnt);
        end
        $display("txn load count after 3 loads + 2 stores: %0d", load_cnt);
        force dut.load_cnt_q = 32'hFFFFFFFF;
        #1;
        release dut.load_cnt_q;
        #1;
        ex_to_mem_valid = 1'b1;
        ex_to_mem_bus = mk_bus(32'h5100, 1'b1, 1'b1, 5'd1, 32'h0, 2'd0, 3'b000);
        tick();
        ex_to_mem_valid = 1'b0;
        tick();
        checks++;
        if (load_cnt !== 32'd0) begin
            failures++;
            $display("FAIL cnt_wrap got=%h want=0", load_cnt);
        end
        $display("txn load count wrap: %h", load_cnt);
    endtask
`endif

    initial begin
        test_reset();
        test_loads();
        test_stall();
        test_back_to_back();
        test_reset_mid_stall();
`ifdef MEM_LOAD_STATS_EN
        test_load_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
